pipe_adder: RTL and testbench

- Parametrised, pipelined carry-select adder/subtractor; successor to the fixed 32-bit single-cycle adder.
- Operand width, carry-select block size and pipeline depth are configurable.
- Adds add/sub mode, status flags and a valid/ready handshake so it can sit between registered datapath stages (ALU, address generation) without limiting clock frequency.

---
 rtl/pipe_adder_pkg.sv | 33 +++
 rtl/csel_block.sv | 39 +++
 rtl/pipe_adder.sv | 169 ++++++++++++++++
 tb/tb_pipe_adder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared configuration helpers and result flag types for the pipelined carry-select adder.
package pipe_adder_pkg;

    localparam int unsigned DEF_WIDTH  = 32;
    localparam int unsigned DEF_BLOCK  = 4;
    localparam int unsigned DEF_STAGES = 2;

    // A configuration is usable only when every stage holds a whole number of blocks.
    function automatic bit cfg_legal(input int unsigned width,
                                     input int unsigned block,
                                     input int unsigned stages);
        if (stages < 1 || block < 1) return 1'b0;
        return (width % (block * stages)) == 0;
    endfunction

    function automatic int unsigned slice_width(input int unsigned width,
                                                input int unsigned stages);
        return width / stages;
    endfunction

    function automatic int unsigned block_count(input int unsigned width,
                                                input int unsigned block,
                                                input int unsigned stages);
        return (width / stages) / block;
    endfunction

    typedef struct packed {
        logic co;
        logic ovf;
        logic zero;
    } flags_t;

endpackage

// File: rtl/csel_block.sv
// Combinational carry-select block; SELECT=0 degenerates to a plain ripple-carry block.
module csel_block #(
    parameter int unsigned W      = 4,
    parameter bit          SELECT = 1'b1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    function automatic logic [W:0] ripple(input logic [W-1:0] x,
                                          input logic [W-1:0] y,
                                          input logic         c);
        logic [W:0] r;
        logic       cc;
        r  = '0;
        cc = c;
        for (int i = 0; i < int'(W); i++) begin
            r[i] = x[i] ^ y[i] ^ cc;
            cc   = (x[i] & y[i]) | (cc & (x[i] ^ y[i]));
        end
        r[W] = cc;
        return r;
    endfunction

    if (SELECT) begin : g_sel
        logic [W:0] r0;
        logic [W:0] r1;
        // Both carry-in outcomes are precomputed; the late carry only drives the mux.
        assign r0      = ripple(a, b, 1'b0);
        assign r1      = ripple(a, b, 1'b1);
        assign {co, s} = ci ? r1 : r0;
    end else begin : g_rip
        assign {co, s} = ripple(a, b, ci);
    end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready handshake and status flags.
// Optional signed saturation of the result when PIPE_ADDER_SAT_EN is defined.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned BLOCK  = DEF_BLOCK,
    parameter int unsigned STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned SLICE = slice_width(WIDTH, STAGES);
    localparam int unsigned NBLK  = block_count(WIDTH, BLOCK, STAGES);
    localparam int unsigned LAST  = STAGES - 1;
    localparam int unsigned NPIPE = (STAGES > 1) ? STAGES - 1 : 1;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        flags_t           f;
    } result_t;

    if (!cfg_legal(WIDTH, BLOCK, STAGES)) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be a multiple of BLOCK*STAGES and STAGES >= 1");
    end

    // Global stall: every stage moves together or not at all.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Inter-stage registers: index k holds what stage k produced for stage k+1.
    logic [WIDTH-1:0] pa [NPIPE];
    logic [WIDTH-1:0] pb [NPIPE];
    logic [WIDTH-1:0] ps [NPIPE];
    logic             pc [NPIPE];
    logic             pv [NPIPE];

    // Inputs seen by each stage: stage 0 from the ports, later stages from registers.
    logic [WIDTH-1:0] src_a [STAGES];
    logic [WIDTH-1:0] src_b [STAGES];
    logic [WIDTH-1:0] src_s [STAGES];
    logic             src_c [STAGES];
    logic             src_v [STAGES];

    always_comb begin
        src_a[0] = a;
        src_b[0] = sub ? ~b : b;
        src_s[0] = '0;
        src_c[0] = sub | ci;
        src_v[0] = in_valid;
        for (int k = 1; k < int'(STAGES); k++) begin
            src_a[k] = pa[k-1];
            src_b[k] = pb[k-1];
            src_s[k] = ps[k-1];
            src_c[k] = pc[k-1];
            src_v[k] = pv[k-1];
        end
    end

    logic [SLICE-1:0] slice_sum [STAGES];
    logic             slice_co  [STAGES];

    for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
        logic [NBLK:0]    bc;
        logic [SLICE-1:0] sum;

        assign bc[0] = src_c[k];

        // Lowest block ripples from the stage carry; the rest select on it.
        for (genvar j = 0; j < int'(NBLK); j++) begin : g_blk
            csel_block #(
                .W      (BLOCK),
                .SELECT (j != 0)
            ) u_blk (
                .a  (src_a[k][k*SLICE + j*BLOCK +: BLOCK]),
                .b  (src_b[k][k*SLICE + j*BLOCK +: BLOCK]),
                .ci (bc[j]),
                .s  (sum[j*BLOCK +: BLOCK]),
                .co (bc[j+1])
            );
        end

        assign slice_sum[k] = sum;
        assign slice_co[k]  = bc[NBLK];
    end

    // Accumulated result: lower slices from earlier stages plus this stage's slice.
    logic [WIDTH-1:0] merged [STAGES];

    always_comb begin
        for (int k = 0; k < int'(STAGES); k++) begin
            merged[k]                  = src_s[k];
            merged[k][k*SLICE +: SLICE] = slice_sum[k];
        end
    end

    if (STAGES > 1) begin : g_pipe
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < int'(LAST); k++) pv[k] <= 1'b0;
            end else if (en) begin
                for (int k = 0; k < int'(LAST); k++) pv[k] <= src_v[k];
            end
        end

        // Payload is qualified by the valid bits, so it carries no reset.
        always_ff @(posedge clk) begin
            if (en) begin
                for (int k = 0; k < int'(LAST); k++) begin
                    pa[k] <= src_a[k];
                    pb[k] <= src_b[k];
                    ps[k] <= merged[k];
                    pc[k] <= slice_co[k];
                end
            end
        end
    end

    result_t fin;

    // Final stage: flags from the effective operands, optional saturation, zero last.
    always_comb begin
        logic msb_carry;
        fin.s      = merged[LAST];
        fin.f.co   = slice_co[LAST];
        msb_carry  = src_a[LAST][WIDTH-1] ^ src_b[LAST][WIDTH-1] ^ fin.s[WIDTH-1];
        fin.f.ovf  = msb_carry ^ fin.f.co;
`ifdef PIPE_ADDER_SAT_EN
        if (fin.f.ovf) begin
            fin.s = src_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        fin.f.zero = (fin.s == '0);
    end

    result_t res_q;

    // Output register holds the last result whenever no new valid slot arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            res_q     <= '0;
        end else if (en) begin
            out_valid <= src_v[LAST];
            if (src_v[LAST]) res_q <= fin;
        end
    end

    assign s    = res_q.s;
    assign co   = res_q.f.co;
    assign ovf  = res_q.f.ovf;
    assign zero = res_q.f.zero;

endmodule

// File: tb/tb_pipe_adder.sv
// Directed self-checking bench for pipe_adder: default 32/4/2 plus 64/8/4 and 16/4/1 instances.
module tb_pipe_adder;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, ci, sub, out_valid, out_ready, co, ovf, zero;
    logic [31:0] a, b, s;

    logic        in_valid64, in_ready64, ci64, sub64, out_valid64, out_ready64, co64, ovf64, zero64;
    logic [63:0] a64, b64, s64;

    logic        in_valid16, in_ready16, ci16, sub16, out_valid16, out_ready16, co16, ovf16, zero16;
    logic [15:0] a16, b16, s16;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [31:0] vec_a   [8] = '{32'h7FFF_FFFF, 32'h0000_0005, 32'h1234_5678, 32'h0000_0000,
                                 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_FFFF, 32'h0000_0010};
    logic [31:0] vec_b   [8] = '{32'h0000_0000, 32'h0000_0007, 32'h9ABC_DEF0, 32'h0000_0000,
                                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0003};
    logic        vec_ci  [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        vec_sub [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    pipe_adder u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .co(co), .ovf(ovf), .zero(zero)
    );

    pipe_adder #(.WIDTH(64), .BLOCK(8), .STAGES(4)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64),
        .a(a64), .b(b64), .ci(ci64), .sub(sub64), .out_valid(out_valid64), .out_ready(out_ready64),
        .s(s64), .co(co64), .ovf(ovf64), .zero(zero64)
    );

    pipe_adder #(.WIDTH(16), .BLOCK(4), .STAGES(1)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .ci(ci16), .sub(sub16), .out_valid(out_valid16), .out_ready(out_ready16),
        .s(s16), .co(co16), .ovf(ovf16), .zero(zero16)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_word(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference: w-bit add/sub with carry-out, signed overflow and optional saturation.
    function automatic void ref_model(input int unsigned w, input logic [63:0] x, input logic [63:0] y,
                                      input logic c_in, input logic do_sub,
                                      output logic [63:0] rs, output logic rco,
                                      output logic rovf, output logic rzero);
        logic [64:0] mask, yeff, full, tmp;
        logic        sx, sy, sr;
        mask = (65'd1 << w) - 65'd1;
        yeff = do_sub ? (~{1'b0, y} & mask) : {1'b0, y};
        full = {1'b0, x} + yeff + {64'd0, do_sub | c_in};
        tmp  = full >> w;
        rco  = tmp[0];
        rs   = 64'(full & mask);
        tmp  = {1'b0, x} >> (w - 1);
        sx   = tmp[0];
        tmp  = yeff >> (w - 1);
        sy   = tmp[0];
        tmp  = {1'b0, rs} >> (w - 1);
        sr   = tmp[0];
        rovf = (sx == sy) && (sr != sx);
`ifdef PIPE_ADDER_SAT_EN
        if (rovf) rs = sx ? 64'(65'd1 << (w - 1)) : 64'(mask >> 1);
`endif
        rzero = (rs == 64'd0);
    endfunction

    task automatic drive(input int idx);
        in_valid = 1'b1;
        a        = vec_a[idx];
        b        = vec_b[idx];
        ci       = vec_ci[idx];
        sub      = vec_sub[idx];
    endtask

    task automatic expect_vec(input string tag, input int idx);
        logic [63:0] es;
        logic        eco, eovf, ezero;
        ref_model(32, 64'(vec_a[idx]), 64'(vec_b[idx]), vec_ci[idx], vec_sub[idx], es, eco, eovf, ezero);
        check_bit({tag, "_valid"}, out_valid, 1'b1);
        check_word({tag, "_s"}, 64'(s), es);
        check_bit({tag, "_co"}, co, eco);
        check_bit({tag, "_ovf"}, ovf, eovf);
        check_bit({tag, "_zero"}, zero, ezero);
    endtask

    initial begin
        logic [63:0] es;
        logic        eco, eovf, ezero;

        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b1;
        in_valid64 = 1'b0; a64 = '0; b64 = '0; ci64 = 1'b0; sub64 = 1'b0; out_ready64 = 1'b1;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0; sub16 = 1'b0; out_ready16 = 1'b1;

        // Reset state
        repeat (2) tick();
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_word("rst_s", 64'(s), 64'd0);
        check_bit("rst_co", co, 1'b0);
        check_bit("rst_ovf", ovf, 1'b0);
        check_bit("rst_zero", zero, 1'b0);
        check_bit("rst_in_ready", in_ready, 1'b1);
        check_bit("rst_valid64", out_valid64, 1'b0);
        check_bit("rst_valid16", out_valid16, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // 1 + 0xFFFFFFFF wraps to zero with carry out
        in_valid = 1'b1; a = 32'h0000_0001; b = 32'hFFFF_FFFF; ci = 1'b0; sub = 1'b0;
        tick();
        in_valid = 1'b0;
        check_bit("t1_not_yet", out_valid, 1'b0);
        tick();
        check_bit("t1_valid", out_valid, 1'b1);
        check_word("t1_s", 64'(s), 64'h0);
        check_bit("t1_co", co, 1'b1);
        check_bit("t1_zero", zero, 1'b1);
        check_bit("t1_ovf", ovf, 1'b0);

        // 0x80000000 - 1 overflows negative
        in_valid = 1'b1; a = 32'h8000_0000; b = 32'h0000_0001; ci = 1'b0; sub = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check_bit("t2_valid", out_valid, 1'b1);
`ifdef PIPE_ADDER_SAT_EN
        check_word("t2_s", 64'(s), 64'h8000_0000);
`else
        check_word("t2_s", 64'(s), 64'h7FFF_FFFF);
`endif
        check_bit("t2_co", co, 1'b1);
        check_bit("t2_ovf", ovf, 1'b1);
        check_bit("t2_zero", zero, 1'b0);
        tick();
        check_bit("t2_drained", out_valid, 1'b0);

        // Back-to-back stream, one result per cycle in order
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) drive(i);
            else in_valid = 1'b0;
            tick();
            if (i == 0) check_bit("b2b_first_empty", out_valid, 1'b0);
            else expect_vec($sformatf("b2b%0d", i - 1), i - 1);
        end
        tick();
        check_bit("b2b_drained", out_valid, 1'b0);

        // Backpressure with the pipeline full
        out_ready = 1'b0;
        drive(2);
        tick();
        drive(6);
        tick();
        drive(7);
        ref_model(32, 64'(vec_a[2]), 64'(vec_b[2]), vec_ci[2], vec_sub[2], es, eco, eovf, ezero);
        for (int i = 0; i < 5; i++) begin
            check_bit("bp_in_ready", in_ready, 1'b0);
            check_bit("bp_valid", out_valid, 1'b1);
            check_word("bp_s_stable", 64'(s), es);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check_bit("bp_release_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        expect_vec("bp_second", 6);
        tick();
        expect_vec("bp_third", 7);
        tick();
        check_bit("bp_no_dup", out_valid, 1'b0);

        // Reset while two transfers are in flight
        drive(0);
        tick();
        drive(1);
        tick();
        in_valid = 1'b0;
        check_bit("mr_pre_valid", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_bit("mr_async_drop", out_valid, 1'b0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_bit("mr_stays_low", out_valid, 1'b0);
        end
        drive(3);
        tick();
        in_valid = 1'b0;
        tick();
        expect_vec("mr_new", 3);

        // 16-bit single-stage instance: latency 1
        in_valid16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0000; ci16 = 1'b1; sub16 = 1'b0;
        check_bit("w16_ready", in_ready16, 1'b1);
        tick();
        check_bit("w16_valid", out_valid16, 1'b1);
        check_word("w16_s", 64'(s16), 64'h0);
        check_bit("w16_co", co16, 1'b1);
        check_bit("w16_zero", zero16, 1'b1);
        check_bit("w16_ovf", ovf16, 1'b0);
        a16 = 16'h8000; b16 = 16'h0001; ci16 = 1'b0; sub16 = 1'b1;
        tick();
        in_valid16 = 1'b0;
        ref_model(16, 64'h8000, 64'h0001, 1'b0, 1'b1, es, eco, eovf, ezero);
        check_word("w16_sub_s", 64'(s16), es);
        check_bit("w16_sub_co", co16, eco);
        check_bit("w16_sub_ovf", ovf16, eovf);
        tick();
        check_bit("w16_drained", out_valid16, 1'b0);

        // 64-bit four-stage instance: carry crosses all stage boundaries, latency 4
        in_valid64 = 1'b1; a64 = 64'hFFFF_FFFF_FFFF_FFFF; b64 = 64'h0; ci64 = 1'b1; sub64 = 1'b0;
        check_bit("w64_ready", in_ready64, 1'b1);
        tick();
        a64 = 64'h7FFF_FFFF_FFFF_FFFF; b64 = 64'h1; ci64 = 1'b0; sub64 = 1'b0;
        check_bit("w64_lat1", out_valid64, 1'b0);
        tick();
        in_valid64 = 1'b0;
        check_bit("w64_lat2", out_valid64, 1'b0);
        tick();
        check_bit("w64_lat3", out_valid64, 1'b0);
        tick();
        check_bit("w64_valid", out_valid64, 1'b1);
        check_word("w64_s", s64, 64'h0);
        check_bit("w64_co", co64, 1'b1);
        check_bit("w64_zero", zero64, 1'b1);
        tick();
        ref_model(64, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, es, eco, eovf, ezero);
        check_bit("w64_2_valid", out_valid64, 1'b1);
        check_word("w64_2_s", s64, es);
        check_bit("w64_2_ovf", ovf64, eovf);
        check_bit("w64_2_co", co64, eco);
        tick();
        check_bit("w64_drained", out_valid64, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
